// File: rtl/dot_prod_accum_pkg.sv
// Shared definitions for the dot-product accumulator: the sign-magnitude
// fixed-point format (bit 31 sign, bits 30:0 magnitude, 15 fractional bits)
// and the controller state encoding.
package dot_prod_accum_pkg;

    localparam int FX_W    = 32;
    localparam int MAG_W   = FX_W - 1;
    localparam int FX_FRAC = 15;

    localparam logic [MAG_W-1:0] MAG_MAX = 31'h7FFF_FFFF;
    localparam logic [FX_W-1:0]  FX_ONE  = 32'h0000_8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Packs a sign and magnitude, forcing a zero magnitude to positive zero.
    function automatic logic [FX_W-1:0] fx_pack(input logic sign, input logic [MAG_W-1:0] mag);
        return {sign && (mag != '0), mag};
    endfunction

endpackage

// File: rtl/dot_prod_accum_fx_mac_sat.sv
// fx_mac_sat: purely combinational multiply-accumulate step in sign-magnitude
// fixed point. Returns acc + weight*node with magnitude saturation; ovf flags
// that either the product or the sum had to be clamped.
import dot_prod_accum_pkg::*;

module fx_mac_sat (
    input  logic [FX_W-1:0] acc,
    input  logic [FX_W-1:0] weight,
    input  logic [FX_W-1:0] node,
    output logic [FX_W-1:0] sum,
    output logic            ovf
);

    logic [2*MAG_W-1:0] mag_prod;
    logic [2*MAG_W-1:0] prod_shift;
    logic [MAG_W-1:0]   prod_mag;
    logic               prod_sign;
    logic               prod_ovf;
    logic [MAG_W:0]     mag_sum;
    logic [MAG_W-1:0]   res_mag;
    logic               res_sign;
    logic               add_ovf;

    // Form the truncated, saturated product and add it to the running sum.
    always_comb begin
        mag_prod   = {{MAG_W{1'b0}}, weight[MAG_W-1:0]} * {{MAG_W{1'b0}}, node[MAG_W-1:0]};
        prod_shift = mag_prod >> FX_FRAC;
        prod_ovf   = 1'b0;
        prod_mag   = prod_shift[MAG_W-1:0];
        if (prod_shift[2*MAG_W-1:MAG_W] != '0) begin
            prod_mag = MAG_MAX;
            prod_ovf = 1'b1;
        end
        prod_sign = (weight[FX_W-1] ^ node[FX_W-1]) && (prod_mag != '0);

        mag_sum  = '0;
        add_ovf  = 1'b0;
        res_mag  = '0;
        res_sign = 1'b0;
        if (acc[FX_W-1] == prod_sign) begin
            mag_sum  = {1'b0, acc[MAG_W-1:0]} + {1'b0, prod_mag};
            res_sign = prod_sign;
            if (mag_sum[MAG_W]) begin
                res_mag = MAG_MAX;
                add_ovf = 1'b1;
            end else begin
                res_mag = mag_sum[MAG_W-1:0];
            end
        end else if (acc[MAG_W-1:0] >= prod_mag) begin
            res_mag  = acc[MAG_W-1:0] - prod_mag;
            res_sign = acc[FX_W-1];
        end else begin
            res_mag  = prod_mag - acc[MAG_W-1:0];
            res_sign = prod_sign;
        end

        sum = fx_pack(res_sign, res_mag);
        ovf = prod_ovf | add_ovf;
    end

endmodule

// File: rtl/dot_prod_accum.sv
// dot_prod_accum: accumulates a stream of weight/input pairs into one
// sign-magnitude output-node value, then holds it until it is consumed.
// Optional build macro DOT_PROD_ACCUM_RELU_EN clamps negative results to zero
// on out_data (count and overflow flag are unaffected).
import dot_prod_accum_pkg::*;

module dot_prod_accum #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FX_W-1:0]   in_weight,
    input  logic [FX_W-1:0]   in_node,
    input  logic              in_last,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FX_W-1:0]   out_data,
    output logic [CNT_W-1:0]  out_terms,
    output logic              out_ovf
);

    state_t           state;
    state_t           state_next;
    logic [FX_W-1:0]  acc;
    logic [FX_W-1:0]  acc_next;
    logic [CNT_W-1:0] terms;
    logic [CNT_W-1:0] terms_next;
    logic             ovf;
    logic             ovf_next;
    logic [FX_W-1:0]  mac_sum;
    logic             mac_ovf;
    logic             accept;
    logic             out_fire;

    fx_mac_sat u_mac (
        .acc    (acc),
        .weight (in_weight),
        .node   (in_node),
        .sum    (mac_sum),
        .ovf    (mac_ovf)
    );

    // Handshake flags are decoded from the state register only.
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_terms = terms;
    assign out_ovf   = ovf;

`ifdef DOT_PROD_ACCUM_RELU_EN
    assign out_data = acc[FX_W-1] ? '0 : acc;
`else
    assign out_data = acc;
`endif

    // Next-state and datapath update; flush overrides any accept or handshake.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        terms_next = terms;
        ovf_next   = ovf;
        if (flush) begin
            state_next = IDLE;
            acc_next   = '0;
            terms_next = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_next   = mac_sum;
                        ovf_next   = ovf | mac_ovf;
                        terms_next = (terms == {CNT_W{1'b1}}) ? terms
                                   : terms + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_next = in_last ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (out_fire) begin
                        state_next = IDLE;
                        acc_next   = '0;
                        terms_next = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    acc_next   = '0;
                    terms_next = '0;
                    ovf_next   = 1'b0;
                end
            endcase
        end
    end

    // State and accumulator registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            terms <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            terms <= terms_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_dot_prod_accum.sv
// Self-checking bench for dot_prod_accum: directed vector table, hand-written
// backpressure/flush/reset sequences, and random dot products compared
// against an integer-arithmetic reference model.
module tb_dot_prod_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_weight;
    logic [31:0] in_node;
    logic        in_last;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_terms;
    logic        out_ovf;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ws[8];
    logic [31:0] ns[8];

    typedef struct {
        string       name;
        int          npairs;
        logic [31:0] w0, n0, w1, n1;
        logic [31:0] exp_data;
        int          exp_terms;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[7];

    dot_prod_accum #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .in_node   (in_node),
        .in_last   (in_last),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_terms (out_terms),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Presents one pair and holds it until accepted (called at posedge+1).
    task automatic applyStimulus(input logic [31:0] w, input logic [31:0] n, input logic last);
        int cnt = 0;
        in_valid  = 1'b1;
        in_weight = w;
        in_node   = n;
        in_last   = last;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!in_ready) checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Waits for a result, stalls for 'delay' cycles, then consumes it.
    task automatic getResult(input int delay, output logic [31:0] d, output logic [31:0] t, output logic o);
        int cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("result_timeout", {31'd0, out_valid}, 32'd1);
        d = out_data;
        t = {16'd0, out_terms};
        o = out_ovf;
        repeat (delay) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Reference: plain signed integer accumulation with magnitude clamping.
    function automatic void model_dot(input int n, output logic [31:0] d, output logic o);
        longint          acc_v = 0;
        longint          maxv  = 64'h7FFF_FFFF;
        longint unsigned a, b, p;
        logic            ov = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = ws[i][30:0];
            b = ns[i][30:0];
            p = (a * b) >> 15;
            if (p > longint'(maxv)) begin
                p  = maxv;
                ov = 1'b1;
            end
            if (ws[i][31] ^ ns[i][31]) acc_v = acc_v - longint'(p);
            else                        acc_v = acc_v + longint'(p);
            if (acc_v > maxv) begin
                acc_v = maxv;
                ov    = 1'b1;
            end else if (acc_v < -maxv) begin
                acc_v = -maxv;
                ov    = 1'b1;
            end
        end
        if (acc_v < 0) d = {1'b1, 31'(-acc_v)};
        else           d = {1'b0, 31'(acc_v)};
`ifdef DOT_PROD_ACCUM_RELU_EN
        if (acc_v < 0) d = 32'h0;
`endif
        o = ov;
    endfunction

    initial begin
        logic [31:0] d, t;
        logic        o;
        logic [31:0] exp_d;
        logic        exp_o;
        logic [31:0] hold_d;
        logic [31:0] hold_t;
        logic        hold_o;
        int          np;

        vecs[0] = '{"basic_sum", 2, 32'h0000_8000, 32'h0001_0000, 32'h0000_C000, 32'h0001_0000, 32'h0002_8000, 2, 1'b0};
`ifdef DOT_PROD_ACCUM_RELU_EN
        vecs[1] = '{"signed", 2, 32'h0000_8000, 32'h0001_0000, 32'h8000_8000, 32'h0001_8000, 32'h0000_0000, 2, 1'b0};
`else
        vecs[1] = '{"signed", 2, 32'h0000_8000, 32'h0001_0000, 32'h8000_8000, 32'h0001_8000, 32'h8000_8000, 2, 1'b0};
`endif
        vecs[2] = '{"prod_sat", 1, 32'h0080_0000, 32'h0080_0000, 32'h0, 32'h0, 32'h7FFF_FFFF, 1, 1'b1};
        vecs[3] = '{"cancel", 2, 32'h0000_8000, 32'h0000_8000, 32'h8000_8000, 32'h0000_8000, 32'h0000_0000, 2, 1'b0};
        vecs[4] = '{"sum_sat", 2, 32'h4000_0000, 32'h0000_8000, 32'h4000_0000, 32'h0000_8000, 32'h7FFF_FFFF, 2, 1'b1};
        vecs[5] = '{"neg_zero_prod", 1, 32'h8000_0000, 32'h0000_8000, 32'h0, 32'h0, 32'h0000_0000, 1, 1'b0};
        vecs[6] = '{"truncate", 1, 32'h0000_0003, 32'h0000_4000, 32'h0, 32'h0, 32'h0000_0001, 1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_weight = '0;
        in_node   = '0;
        in_last   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_terms", {16'd0, out_terms}, 32'd0);
        checkOutput("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].npairs == 2) begin
                applyStimulus(vecs[i].w0, vecs[i].n0, 1'b0);
                applyStimulus(vecs[i].w1, vecs[i].n1, 1'b1);
            end else begin
                applyStimulus(vecs[i].w0, vecs[i].n0, 1'b1);
            end
            checkOutput({vecs[i].name, "_latency"}, {31'd0, out_valid}, 32'd1);
            getResult(0, d, t, o);
            checkOutput({vecs[i].name, "_data"}, d, vecs[i].exp_data);
            checkOutput({vecs[i].name, "_terms"}, t, 32'(vecs[i].exp_terms));
            checkOutput({vecs[i].name, "_ovf"}, {31'd0, o}, {31'd0, vecs[i].exp_ovf});
        end

        // Backpressure: result held stable while out_ready is low
        applyStimulus(32'h0000_8000, 32'h0001_0000, 1'b0);
        applyStimulus(32'h0080_0000, 32'h0080_0000, 1'b1);
        hold_d = out_data;
        hold_t = {16'd0, out_terms};
        hold_o = out_ovf;
        checkOutput("bp_data_value", hold_d, 32'h7FFF_FFFF);
        checkOutput("bp_terms_value", hold_t, 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_data", out_data, hold_d);
            checkOutput("bp_terms", {16'd0, out_terms}, hold_t);
            checkOutput("bp_ovf", {31'd0, out_ovf}, {31'd0, hold_o});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_release_ovf", {31'd0, out_ovf}, 32'd0);

        // Flush together with the last pair
        applyStimulus(32'h0000_8000, 32'h0000_8000, 1'b0);
        checkOutput("pre_flush_terms", {16'd0, out_terms}, 32'd1);
        in_valid  = 1'b1;
        in_weight = 32'h0000_8000;
        in_node   = 32'h0000_8000;
        in_last   = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("flush_no_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("flush_terms", {16'd0, out_terms}, 32'd0);
            checkOutput("flush_data", out_data, 32'd0);
            @(posedge clk); #1;
        end

        // Reset pulse in the middle of an accumulation
        applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b0);
        applyStimulus(32'h0001_0000, 32'h0000_8000, 1'b0);
        checkOutput("pre_rst_terms", {16'd0, out_terms}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_data", out_data, 32'd0);
        checkOutput("mid_rst_terms", {16'd0, out_terms}, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_ovf", {31'd0, out_ovf}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'h0000_8000, 32'h0000_8000, 1'b1);
        getResult(1, d, t, o);
        checkOutput("post_rst_data", d, 32'h0000_8000);
        checkOutput("post_rst_terms", t, 32'd1);

        // Random dot products against the reference model
        for (int k = 0; k < 40; k++) begin
            np = $urandom_range(1, 6);
            for (int i = 0; i < np; i++) begin
                if ($urandom_range(9) == 0) ws[i] = $urandom;
                else ws[i] = {1'($urandom_range(1)), 31'($urandom_range(0, 32'h3FFFF))};
                if ($urandom_range(9) == 0) ns[i] = $urandom;
                else ns[i] = {1'($urandom_range(1)), 31'($urandom_range(0, 32'h3FFFF))};
            end
            model_dot(np, exp_d, exp_o);
            for (int i = 0; i < np; i++) applyStimulus(ws[i], ns[i], i == np - 1);
            getResult(int'($urandom_range(3)), d, t, o);
            checkOutput("rand_data", d, exp_d);
            checkOutput("rand_terms", t, 32'(np));
            checkOutput("rand_ovf", {31'd0, o}, {31'd0, exp_o});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
